permutation_ctrl: RTL and testbench



---
 rtl/permutation_ctrl_pkg.sv | 23 ++
 rtl/permutation_ctrl_round.sv | 64 ++++++
 rtl/permutation_ctrl.sv | 91 +++++++++
 tb/tb_permutation_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/permutation_ctrl_pkg.sv
// Shared Ascon types, constants and helpers for the permutation controller and its round datapath.
package ascon_pack;

    typedef logic [4:0][63:0] state_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} perm_state_t;

    localparam int         MAX_ROUNDS = 12;
    localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

    // Per-word rotation pairs of the linear layer, indexed by word number.
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'd15 - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/permutation_ctrl_round.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit S-box layer, linear diffusion.
module sublayer
    import ascon_pack::*;
(
    input  state_t x_i,
    output state_t x_o
);

    state_t w_a;
    state_t w_t;
    state_t w_b;

    always_comb begin
        w_a    = x_i;
        w_a[0] = x_i[0] ^ x_i[4];
        w_a[4] = x_i[4] ^ x_i[3];
        w_a[2] = x_i[2] ^ x_i[1];
        w_t    = '0;
        w_b    = '0;
        // Chi-like nonlinear step across the five words, wrapping from word 4 back to word 0.
        for (int i = 0; i < 5; i++) begin
            w_t[i] = ~w_a[i] & w_a[(i + 1) % 5];
        end
        for (int i = 0; i < 5; i++) begin
            w_b[i] = w_a[i] ^ w_t[(i + 1) % 5];
        end
        x_o    = w_b;
        x_o[1] = w_b[1] ^ w_b[0];
        x_o[0] = w_b[0] ^ w_b[4];
        x_o[3] = w_b[3] ^ w_b[2];
        x_o[2] = ~w_b[2];
    end

endmodule

module round_function
    import ascon_pack::*;
(
    input  state_t     state_i,
    input  logic [3:0] round_i,
    output state_t     state_o
);

    state_t w_added;
    state_t w_subst;

    always_comb begin
        w_added       = state_i;
        w_added[2][7:0] = state_i[2][7:0] ^ round_const(round_i);
    end

    sublayer u_sublayer (
        .x_i (w_added),
        .x_o (w_subst)
    );

    always_comb begin
        state_o = w_subst;
        for (int i = 0; i < 5; i++) begin
            state_o[i] = w_subst[i] ^ ror64(w_subst[i], ROT_A[i]) ^ ror64(w_subst[i], ROT_B[i]);
        end
    end

endmodule

// File: rtl/permutation_ctrl.sv
// Iterative Ascon p^n controller: one round per clock on a registered state, start/ready in, valid pulse out.
module permutation_ctrl
    import ascon_pack::*;
#(
    parameter int DEFAULT_ROUNDS = 12
)
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [3:0] rounds_i,
    input  state_t     state_i,
    output logic       ready_o,
    output logic       valid_o,
    output logic       busy_o,
    output state_t     state_o
);

    perm_state_t r_state;
    perm_state_t w_next;
    logic [3:0]  r_round;
    logic [3:0]  w_rounds;
    state_t      r_data;
    state_t      w_roundOut;
    logic        w_accept;

    round_function u_round (
        .state_i (r_data),
        .round_i (r_round),
        .state_o (w_roundOut)
    );

    always_comb begin
        w_rounds = rounds_i;
        if (rounds_i == 4'd0 || rounds_i > 4'(MAX_ROUNDS)) begin
            w_rounds = 4'(DEFAULT_ROUNDS);
        end
    end

    // A start during RUN is dropped on purpose; only IDLE and DONE accept work.
    assign w_accept = start_i && (r_state != RUN);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        ready_o = 1'b1;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_next = RUN;
            end
            RUN: begin
                ready_o = 1'b0;
                busy_o  = 1'b1;
                if (r_round == LAST_ROUND) w_next = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                w_next  = start_i ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Starting at 12-n makes every job end on round index 11, so the last constant is always 0x4b.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_data  <= '0;
            r_round <= 4'd0;
        end else if (w_accept) begin
            r_data  <= state_i;
            r_round <= 4'(MAX_ROUNDS) - w_rounds;
        end else if (r_state == RUN) begin
            r_data <= w_roundOut;
            if (r_round != LAST_ROUND) begin
                r_round <= r_round + 4'd1;
            end
        end
    end

    assign state_o = r_data;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Directed-random bench for permutation_ctrl against a table-driven Ascon permutation model.
module tb_permutation_ctrl;

    logic               clock    = 1'b0;
    logic               reset    = 1'b1;
    logic               startIn  = 1'b0;
    logic [3:0]         roundsIn = 4'd0;
    ascon_pack::state_t stateIn  = '0;
    ascon_pack::state_t stateOut;
    logic               readyOut;
    logic               validOut;
    logic               busyOut;

    int vectors     = 0;
    int miscompares = 0;

    logic [4:0] sboxTable [32];

    permutation_ctrl #(.DEFAULT_ROUNDS(12)) dut (
        .clock_i  (clock),
        .reset_i  (reset),
        .start_i  (startIn),
        .rounds_i (roundsIn),
        .state_i  (stateIn),
        .ready_o  (readyOut),
        .valid_o  (validOut),
        .busy_o   (busyOut),
        .state_o  (stateOut)
    );

    always #5 clock = ~clock;

    // Hard stop in case something upstream stalls beyond every local bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One reference round: S-box applied column by column from its lookup table.
    function automatic ascon_pack::state_t refRound(input ascon_pack::state_t s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  res;
        for (int i = 0; i < 5; i++) begin
            x[i] = s[i];
            y[i] = '0;
        end
        x[2] = x[2] ^ 64'((15 - r) * 16 + r);
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            res = sboxTable[col];
            y[0][b] = res[4];
            y[1][b] = res[3];
            y[2][b] = res[2];
            y[3][b] = res[1];
            y[4][b] = res[0];
        end
        s[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
        s[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
        s[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
        s[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
        s[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        return s;
    endfunction

    function automatic ascon_pack::state_t refPerm(input ascon_pack::state_t s, input int n);
        for (int r = 12 - n; r < 12; r++) begin
            s = refRound(s, r);
        end
        return s;
    endfunction

    function automatic ascon_pack::state_t randState();
        ascon_pack::state_t s;
        for (int i = 0; i < 5; i++) begin
            s[i] = {$urandom, $urandom};
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [319:0] observed, input logic [319:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One isolated job; with noise on, start/rounds/state are scrambled throughout RUN.
    task automatic applyStimulus(input logic [3:0] rin, input ascon_pack::state_t s, input int effN, input bit noise);
        ascon_pack::state_t expected;
        int m;
        expected = refPerm(s, effN);
        @(negedge clock);
        checkOutput("readyBeforeStart", 320'(readyOut), 320'(1));
        startIn  = 1'b1;
        roundsIn = rin;
        stateIn  = s;
        m = 0;
        while (m < 40) begin
            @(negedge clock);
            m++;
            if (validOut) break;
            checkOutput("busyDuringRun", 320'(busyOut), 320'(1));
            checkOutput("readyDuringRun", 320'(readyOut), 320'(0));
            if (noise) begin
                startIn  = 1'($urandom);
                roundsIn = 4'($urandom);
                stateIn  = randState();
            end else begin
                startIn = 1'b0;
            end
        end
        startIn = 1'b0;
        checkOutput("latency", 320'(m), 320'(effN + 1));
        checkOutput("result", stateOut, expected);
        @(negedge clock);
        checkOutput("validPulseWidth", 320'(validOut), 320'(0));
        checkOutput("readyAfterDone", 320'(readyOut), 320'(1));
    endtask

    // start_i held high with n=6: each result must arrive 7 clocks after the previous accept.
    task automatic applyBackToBack(input int jobs);
        ascon_pack::state_t inputs [4];
        ascon_pack::state_t expected;
        int m;
        for (int j = 0; j < 4; j++) inputs[j] = randState();
        @(negedge clock);
        startIn  = 1'b1;
        roundsIn = 4'd6;
        stateIn  = inputs[0];
        for (int j = 0; j < jobs; j++) begin
            expected = refPerm(inputs[j], 6);
            m = 0;
            while (m < 40) begin
                @(negedge clock);
                m++;
                if (validOut) break;
                checkOutput("b2bBusy", 320'(busyOut), 320'(1));
                if (m == 1) stateIn = inputs[j + 1];
            end
            checkOutput("b2bLatency", 320'(m), 320'(7));
            checkOutput("b2bResult", stateOut, expected);
            if (j == jobs - 1) startIn = 1'b0;
        end
        @(negedge clock);
        checkOutput("b2bIdleAfter", 320'(validOut), 320'(0));
    endtask

    task automatic applyMidRunReset();
        @(negedge clock);
        startIn  = 1'b1;
        roundsIn = 4'd12;
        stateIn  = randState();
        @(negedge clock);
        startIn = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("resetState", stateOut, 320'(0));
        checkOutput("resetReady", 320'(readyOut), 320'(1));
        checkOutput("resetBusy", 320'(busyOut), 320'(0));
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            checkOutput("noValidAfterAbort", 320'(validOut), 320'(0));
        end
    endtask

    initial begin
        ascon_pack::state_t iv;
        int n;
        sboxTable = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput("idleReady", 320'(readyOut), 320'(1));
            checkOutput("idleValid", 320'(validOut), 320'(0));
            checkOutput("idleBusy", 320'(busyOut), 320'(0));
            checkOutput("idleState", stateOut, 320'(0));
        end

        iv    = '0;
        iv[0] = 64'h80400c0600000000;
        applyStimulus(4'd12, iv, 12, 1'b0);

        applyStimulus(4'd6, randState(), 6, 1'b1);
        applyStimulus(4'd8, randState(), 8, 1'b1);

        applyBackToBack(3);

        applyStimulus(4'd0,  randState(), 12, 1'b0);
        applyStimulus(4'd13, randState(), 12, 1'b1);
        applyStimulus(4'd15, randState(), 12, 1'b0);
        applyStimulus(4'd1,  randState(), 1,  1'b0);

        applyMidRunReset();
        applyStimulus(4'd12, randState(), 12, 1'b0);

        for (int j = 0; j < 4; j++) begin
            n = int'($urandom_range(1, 12));
            applyStimulus(4'(n), randState(), n, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
